// File: rtl/phys_free_list_pkg.sv
// Shared physical/architectural register sizing for rename, ROB and free list.
// Also holds a small helper that counts set bits in a request/free pair.
package phys_free_list_pkg;

  localparam int NUM_PREG = 64;
  localparam int NUM_AREG = 32;
  localparam int PREG_W   = 6;

  typedef logic [PREG_W-1:0] preg_t;

  function automatic logic [1:0] cnt2(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/phys_free_list.sv
// Physical-register free list: circular FIFO of free pregs plus in-list bitmap.
// Latency: alloc outputs combinational from state; allocs/frees take effect at next edge.
// Backpressure: all-or-nothing alloc_gnt; rename stalls when gnt is low, frees never stall.
module phys_free_list
  import phys_free_list_pkg::*;
#(
  parameter int NUM_PREG = phys_free_list_pkg::NUM_PREG,
  parameter int NUM_AREG = phys_free_list_pkg::NUM_AREG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_req_1,
  input  logic              alloc_req_2,
  output logic              alloc_gnt,
  output logic [PREG_W-1:0] alloc_preg_1,
  output logic [PREG_W-1:0] alloc_preg_2,
  input  logic              rt_flag_1,
  input  logic [PREG_W-1:0] fp_i_1,
  input  logic              rt_flag_2,
  input  logic [PREG_W-1:0] fp_i_2,
  output logic [PREG_W:0]   free_count,
  output logic              empty,
  output logic              err_double_free
);

  localparam int CW       = PREG_W + 1;
  localparam int NUM_INIT = NUM_PREG - NUM_AREG;

  preg_t               fifo_q [NUM_PREG];
  preg_t               fifo_d [NUM_PREG];
  preg_t               head_q, head_d;
  preg_t               tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic [NUM_PREG-1:0] in_list_q, in_list_d;
  logic                err_q, err_d;

  logic [1:0] n_req;
  logic [1:0] n_acc;
  logic       dup;
  logic       acc_1, acc_2;
  logic       bad_1, bad_2;
  preg_t      head_p1;
  preg_t      tail_p1;

  assign n_req     = cnt2(alloc_req_1, alloc_req_2);
  assign alloc_gnt = (count_q >= CW'(n_req));
  assign head_p1   = head_q + preg_t'(1);
  assign tail_p1   = tail_q + preg_t'(1);

  assign alloc_preg_1 = fifo_q[head_q];
  assign alloc_preg_2 = alloc_req_1 ? fifo_q[head_p1] : fifo_q[head_q];

  // Frees check the pre-edge bitmap, so freeing a register allocated this cycle is a double free.
  assign dup   = rt_flag_1 && rt_flag_2 && (fp_i_1 == fp_i_2);
  assign acc_1 = rt_flag_1 && (fp_i_1 != '0) && !in_list_q[fp_i_1];
  assign bad_1 = rt_flag_1 && (fp_i_1 != '0) &&  in_list_q[fp_i_1];
  assign acc_2 = rt_flag_2 && (fp_i_2 != '0) && !in_list_q[fp_i_2] && !dup;
  assign bad_2 = rt_flag_2 && (fp_i_2 != '0) && (in_list_q[fp_i_2] || dup);
  assign n_acc = cnt2(acc_1, acc_2);

  always_comb begin
    fifo_d    = fifo_q;
    in_list_d = in_list_q;
    head_d    = head_q;
    if (alloc_gnt) begin
      head_d = head_q + preg_t'(n_req);
      if (alloc_req_1) in_list_d[alloc_preg_1] = 1'b0;
      if (alloc_req_2) in_list_d[alloc_preg_2] = 1'b0;
    end
    if (acc_1) begin
      fifo_d[tail_q]    = fp_i_1;
      in_list_d[fp_i_1] = 1'b1;
    end
    if (acc_2) begin
      fifo_d[acc_1 ? tail_p1 : tail_q] = fp_i_2;
      in_list_d[fp_i_2]                = 1'b1;
    end
    tail_d  = tail_q + preg_t'(n_acc);
    count_d = count_q - (alloc_gnt ? CW'(n_req) : CW'(0)) + CW'(n_acc);
    err_d   = err_q | bad_1 | bad_2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PREG; i++) begin
        fifo_q[i] <= (i < NUM_INIT) ? preg_t'(NUM_AREG + i) : '0;
      end
      head_q    <= '0;
      tail_q    <= preg_t'(NUM_INIT);
      count_q   <= CW'(NUM_INIT);
      in_list_q <= {{NUM_INIT{1'b1}}, {NUM_AREG{1'b0}}};
      err_q     <= 1'b0;
    end else begin
      fifo_q    <= fifo_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      in_list_q <= in_list_d;
      err_q     <= err_d;
    end
  end

  assign free_count      = count_q;
  assign empty           = (count_q == '0);
  assign err_double_free = err_q;

endmodule
